rst_seq_ctrl: RTL and testbench

- Parametrised reset sequencer that generalises the PLL-reset / system-reset pairing to N staged reset outputs.
- Drives the PLL reset pulse and waits for a stable lock, with timeout and retry.
- Releases N active-low domain resets in a fixed order with programmable spacing.
- Re-runs the whole sequence on lock loss or on an external reset request. Sits at the top level between the board reset button, the PLL, and all functional blocks.

---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/sync_ff.sv | 22 ++
 rtl/rst_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int unsigned RETRY_W = 8;

  // Width of a counter that must hold the largest of three terminal values without wrapping.
  function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage bit synchroniser with a configurable reset value.
module sync_ff #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) chain <= {STAGES{RST_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// PLL reset / lock supervisor that releases N active-low domain resets in order.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_OUT          = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_STABLE    = 32,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned STAGE_GAP      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_rst_n,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic [N_OUT-1:0]   sys_rst_n,
  output logic               seq_done,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [1:0]         state
);

  localparam int unsigned CNT_W = cnt_w(LOCK_TIMEOUT, N_OUT * STAGE_GAP, PLL_RST_CYCLES);

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'((N_OUT - 1) * STAGE_GAP);

  logic ext_sync;
  logic lock_sync;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   stable_q, stable_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [N_OUT-1:0]   sys_q, sys_d;
  logic               pll_rst_q;
  logic               done_q;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ext_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_rst_n),
    .q   (ext_sync)
  );

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_sync)
  );

  // Next-state, timer and output decode; external request beats lock loss beats timer events.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    stable_d = '0;
    retry_d  = retry_q;
    sys_d    = sys_q;

    if (!ext_sync) begin
      state_d = ST_PLL_RST;
      timer_d = '0;
      sys_d   = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (timer_q == PLL_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_sync) stable_d = stable_q + 1'b1;
          // A stable lock takes precedence over a timeout landing on the same edge.
          if (lock_sync && (stable_q == STABLE_LAST)) begin
            state_d  = ST_RELEASE;
            timer_d  = '0;
            stable_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d = ST_PLL_RST;
            timer_d = '0;
            if (retry_q != '1) retry_d = retry_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!lock_sync) begin
            state_d = ST_PLL_RST;
            timer_d = '0;
            sys_d   = '0;
          end else begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
              if (timer_q == CNT_W'(k * STAGE_GAP)) sys_d[k] = 1'b1;
            end
            if (timer_q == REL_LAST) begin
              state_d = ST_RUN;
              timer_d = '0;
            end
          end
        end
        ST_RUN: begin
          timer_d = '0;
          if (!lock_sync) begin
            state_d = ST_PLL_RST;
            sys_d   = '0;
          end
        end
        default: begin
          state_d = ST_PLL_RST;
          timer_d = '0;
          sys_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      timer_q   <= '0;
      stable_q  <= '0;
      retry_q   <= '0;
      sys_q     <= '0;
      pll_rst_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      sys_q     <= sys_d;
      pll_rst_q <= (state_d == ST_PLL_RST);
      done_q    <= (state_d == ST_RUN);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_q;
  assign seq_done  = done_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: table-driven scenarios plus hand-written corner sequences.
module tb_rst_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       ext_rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic [2:0] sys_rst_n;
  logic       seq_done;
  logic [7:0] retry_cnt;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic       ext;
    logic       lock;
    logic       pll;
    logic [2:0] sys;
    logic       done;
    logic [7:0] retry;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  rst_seq_ctrl #(
    .N_OUT          (3),
    .SYNC_STAGES    (2),
    .PLL_RST_CYCLES (4),
    .LOCK_STABLE    (8),
    .LOCK_TIMEOUT   (100),
    .STAGE_GAP      (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_rst_n  (ext_rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .seq_done   (seq_done),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int c, input logic e, input logic l, input logic p,
                              input logic [2:0] s, input logic d, input logic [7:0] r,
                              input logic [1:0] st);
    vec_t v;
    v.cyc = c; v.ext = e; v.lock = l; v.pll = p;
    v.sys = s; v.done = d; v.retry = r; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic p, input logic [2:0] s, input logic d,
                         input logic [7:0] r, input logic [1:0] st);
    chk($sformatf("%s@%0d pll_rst", tag, cyc),   32'(pll_rst),   32'(p));
    chk($sformatf("%s@%0d sys_rst_n", tag, cyc), 32'(sys_rst_n), 32'(s));
    chk($sformatf("%s@%0d seq_done", tag, cyc),  32'(seq_done),  32'(d));
    chk($sformatf("%s@%0d retry_cnt", tag, cyc), 32'(retry_cnt), 32'(r));
    chk($sformatf("%s@%0d state", tag, cyc),     32'(state),     32'(st));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  // Leaves the bench in cycle 0: first window after a reset edge, with rst already low.
  task automatic do_reset();
    rst = 1'b1;
    ext_rst_n = 1'b1;
    pll_locked = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_tbl(input string tag);
    do_reset();
    foreach (tbl[i]) begin
      go_to(tbl[i].cyc);
      ext_rst_n  = tbl[i].ext;
      pll_locked = tbl[i].lock;
      chk_out(tag, tbl[i].pll, tbl[i].sys, tbl[i].done, tbl[i].retry, tbl[i].st);
    end
  endtask

  initial begin
    rst = 1'b1;
    ext_rst_n = 1'b1;
    pll_locked = 1'b0;

    // Nominal bring-up, lock from cycle 10.
    tbl.delete();
    tbl.push_back(mk(0,  1, 0, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3,  1, 0, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(4,  1, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(10, 1, 1, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(19, 1, 1, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(20, 1, 1, 0, 3'b000, 0, 0, 2));
    tbl.push_back(mk(21, 1, 1, 0, 3'b001, 0, 0, 2));
    tbl.push_back(mk(25, 1, 1, 0, 3'b001, 0, 0, 2));
    tbl.push_back(mk(26, 1, 1, 0, 3'b011, 0, 0, 2));
    tbl.push_back(mk(30, 1, 1, 0, 3'b011, 0, 0, 2));
    tbl.push_back(mk(31, 1, 1, 0, 3'b111, 1, 0, 3));
    tbl.push_back(mk(60, 1, 1, 0, 3'b111, 1, 0, 3));
    run_tbl("nominal");

    // Lock glitch: 7 high, 1 low, then high; release needs 8 fresh consecutive cycles.
    tbl.delete();
    tbl.push_back(mk(0,  1, 0, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(10, 1, 1, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(17, 1, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(18, 1, 1, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(20, 1, 1, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(27, 1, 1, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(28, 1, 1, 0, 3'b000, 0, 0, 2));
    tbl.push_back(mk(29, 1, 1, 0, 3'b001, 0, 0, 2));
    run_tbl("glitch");

    // Stable and timeout reached on the same edge: release wins, no retry.
    tbl.delete();
    tbl.push_back(mk(0,   1, 0, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(94,  1, 1, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(103, 1, 1, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(104, 1, 1, 0, 3'b000, 0, 0, 2));
    tbl.push_back(mk(105, 1, 1, 0, 3'b001, 0, 0, 2));
    run_tbl("coincide");

    // External reset mid-RELEASE after one timeout (retry_cnt=1 must survive).
    tbl.delete();
    tbl.push_back(mk(0,   1, 0, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(104, 1, 1, 1, 3'b000, 0, 1, 0));
    tbl.push_back(mk(117, 1, 1, 0, 3'b001, 0, 1, 2));
    tbl.push_back(mk(118, 0, 1, 0, 3'b001, 0, 1, 2));
    tbl.push_back(mk(120, 0, 1, 0, 3'b001, 0, 1, 2));
    tbl.push_back(mk(121, 0, 1, 1, 3'b000, 0, 1, 0));
    tbl.push_back(mk(127, 0, 1, 1, 3'b000, 0, 1, 0));
    tbl.push_back(mk(128, 1, 1, 1, 3'b000, 0, 1, 0));
    tbl.push_back(mk(133, 1, 1, 1, 3'b000, 0, 1, 0));
    tbl.push_back(mk(134, 1, 1, 0, 3'b000, 0, 1, 1));
    tbl.push_back(mk(142, 1, 1, 0, 3'b000, 0, 1, 2));
    tbl.push_back(mk(143, 1, 1, 0, 3'b001, 0, 1, 2));
    tbl.push_back(mk(153, 1, 1, 0, 3'b111, 1, 1, 3));
    run_tbl("extrst");

    // Lock loss in RUN after one timeout, then full re-sequence.
    tbl.delete();
    tbl.push_back(mk(0,   1, 0, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(103, 1, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(104, 1, 1, 1, 3'b000, 0, 1, 0));
    tbl.push_back(mk(108, 1, 1, 0, 3'b000, 0, 1, 1));
    tbl.push_back(mk(115, 1, 1, 0, 3'b000, 0, 1, 1));
    tbl.push_back(mk(116, 1, 1, 0, 3'b000, 0, 1, 2));
    tbl.push_back(mk(117, 1, 1, 0, 3'b001, 0, 1, 2));
    tbl.push_back(mk(127, 1, 1, 0, 3'b111, 1, 1, 3));
    tbl.push_back(mk(130, 1, 0, 0, 3'b111, 1, 1, 3));
    tbl.push_back(mk(132, 1, 0, 0, 3'b111, 1, 1, 3));
    tbl.push_back(mk(133, 1, 1, 1, 3'b000, 0, 1, 0));
    tbl.push_back(mk(137, 1, 1, 0, 3'b000, 0, 1, 1));
    tbl.push_back(mk(145, 1, 1, 0, 3'b000, 0, 1, 2));
    tbl.push_back(mk(146, 1, 1, 0, 3'b001, 0, 1, 2));
    tbl.push_back(mk(151, 1, 1, 0, 3'b011, 0, 1, 2));
    tbl.push_back(mk(156, 1, 1, 0, 3'b111, 1, 1, 3));
    run_tbl("lockloss");

    // Synchronous rst in RUN: nothing moves before the edge, everything clears on it.
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst_pre", 1'b0, 3'b111, 1'b1, 8'd1, 2'd3);
    tick();
    chk_out("rst_edge", 1'b1, 3'b000, 1'b0, 8'd0, 2'd0);
    rst = 1'b0;
    tick();
    chk_out("rst_after", 1'b1, 3'b000, 1'b0, 8'd0, 2'd0);

    // Repeating 7-high/1-low lock never qualifies; timeout still fires on schedule.
    do_reset();
    while (cyc < 103) begin
      pll_locked = ((cyc % 8) != 7);
      tick();
    end
    chk_out("chatter", 1'b0, 3'b000, 1'b0, 8'd0, 2'd1);
    tick();
    chk_out("chatter", 1'b1, 3'b000, 1'b0, 8'd1, 2'd0);

    // Lock never arrives: 104-cycle retry period and retry_cnt saturation.
    do_reset();
    go_to(103);   chk_out("timeout", 1'b0, 3'b000, 1'b0, 8'd0,   2'd1);
    go_to(104);   chk_out("timeout", 1'b1, 3'b000, 1'b0, 8'd1,   2'd0);
    go_to(107);   chk_out("timeout", 1'b1, 3'b000, 1'b0, 8'd1,   2'd0);
    go_to(108);   chk_out("timeout", 1'b0, 3'b000, 1'b0, 8'd1,   2'd1);
    go_to(208);   chk_out("timeout", 1'b1, 3'b000, 1'b0, 8'd2,   2'd0);
    go_to(312);   chk_out("timeout", 1'b1, 3'b000, 1'b0, 8'd3,   2'd0);
    go_to(26519); chk_out("timeout", 1'b0, 3'b000, 1'b0, 8'd254, 2'd1);
    go_to(26520); chk_out("timeout", 1'b1, 3'b000, 1'b0, 8'd255, 2'd0);
    go_to(26623); chk_out("timeout", 1'b0, 3'b000, 1'b0, 8'd255, 2'd1);
    go_to(26624); chk_out("timeout", 1'b1, 3'b000, 1'b0, 8'd255, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
